pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register. Successor to the fixed 32-bit stall/clear stage registers between CPU pipeline stages (IF/DE, DE/EX, ...).
- Adds valid/ready flow control, a one-entry skid buffer so `in_ready` depends only on registered state and `flush`, and a configurable bubble (NOP) value.
- The flush port replaces the branch-unit clear. One instance per stage boundary.

Parameters:
- DATA_W, 32, payload width in bits (instruction, PC, or packed control bundle).
- NOP_VALUE, '0 (DATA_W bits), value driven on `out_data` when the stage holds no valid entry.
- CNT_W, 16, width of the performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear from branch/hazard unit. Top priority.
- in_valid  input  1  upstream has data.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  stage accepts `in_data` this cycle.
- out_valid  output  1  stage holds a valid entry.
- out_data  output  DATA_W  payload to the next stage.
- out_ready  input  1  downstream accepts. Low means stall.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_cnt  output  CNT_W  flushes that discarded at least one valid entry.

Behaviour:
- Reset (async, rst_n=0):
  - state=EMPTY, main=NOP_VALUE, skid=NOP_VALUE, counters=0.
  - Outputs: out_valid=0, out_data=NOP_VALUE, in_ready=1 once rst_n=1.
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Combinational outputs:
  - out_valid = (state != EMPTY).
  - out_data = main.
  - in_ready = (state != FULL2) & ~flush.
- Latency: one cycle, in_fire at edge N gives out_valid/out_data at N+1. Throughput: one entry per cycle when out_ready=1.
- States and transitions (no flush):
  - EMPTY:
    - in_fire -> ONE, main<=in_data.
    - Otherwise hold.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire & ~out_fire -> FULL2, skid<=in_data.
    - ~in_fire & out_fire -> EMPTY, main<=NOP_VALUE.
    - Otherwise hold.
  - FULL2 (in_ready=0):
    - out_fire -> ONE, main<=skid, skid<=NOP_VALUE.
    - Otherwise hold.
- Flush (synchronous, overrides all transitions):
  - Next state EMPTY, main<=NOP_VALUE, skid<=NOP_VALUE.
  - in_ready=0 during the flush cycle, so any in_valid that cycle is dropped.
  - An out_fire in the flush cycle still counts as delivered downstream; the consumer is responsible for its own flush.
- Stall hold: out_ready=0 keeps main/skid stable and out_valid high. Data never changes while out_valid=1 and out_ready=0.
- Ordering: strictly FIFO. Skid data is never presented before main.
- Flush held for multiple cycles: stage stays EMPTY with in_ready=0.
- Reset mid-operation: both entries are lost immediately (async).

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - flush_cnt increments on each flush cycle where state != EMPTY.
  - Both saturate at all-ones and do not wrap.
  - Reset to 0 by rst_n only; flush does not clear them.
- Undefined: both ports tied to '0 and no counter flops are inferred. The port list is identical in both builds.

Decomposition:
- Shared package pipe_pkg:
  - State enum pipe_state_e {EMPTY, ONE, FULL2}, 2 bits.
  - Default NOP constant PIPE_NOP_DEFAULT.
  - Shared localparam for default CNT_W.
- One natural sub-module: pipe_sat_cnt, a saturating counter with CNT_W and inc inputs, instantiated twice under PIPE_PERF_CNT_EN.

Test Plan:
- Reset: rst_n=0 mid-stream with 2 entries held -> out_valid=0 and out_data=NOP_VALUE (0x00000000) immediately; in_ready=1 after release.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> same order on out_data, 1-cycle latency, in_ready stays 1.
- Stall and skid:
  - Push 0xA1 then 0xA2 with out_ready=0 -> state FULL2, in_ready=0, out_data=0xA1 held.
  - Raise out_ready for 2 cycles -> 0xA1 then 0xA2 delivered, then out_valid=0.
- Flush: FULL2 with flush=1 and in_valid=1 (0xBB) -> next cycle out_valid=0, out_data=NOP_VALUE, 0xBB never emitted; flush_cnt=1 with PIPE_PERF_CNT_EN.
- Flush priority: flush=1 while out_ready=0 for 3 cycles -> stays EMPTY, in_ready=0 throughout; stall_cnt increments only before the flush.
- Saturation (PIPE_PERF_CNT_EN, CNT_W=4): hold out_ready=0 with a valid entry for 20 cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and defaults for the handshaked pipeline stage register.
//   pipe_state_e       : occupancy state of a stage (EMPTY, ONE, FULL2)
//   PIPE_NOP_DEFAULT   : default bubble value driven when the stage is empty
//   PIPE_CNT_W_DEFAULT : default performance-counter width
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W_DEFAULT = 32;
  localparam int unsigned PIPE_CNT_W_DEFAULT  = 16;

  localparam logic [PIPE_DATA_W_DEFAULT-1:0] PIPE_NOP_DEFAULT = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around one pipeline stage.
//   in_valid/in_data/in_ready    : upstream side of the stage
//   out_valid/out_data/out_ready : downstream side of the stage
//   modport slave  : the stage itself
//   modport master : the environment driving and consuming the stage
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W_DEFAULT
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage_reg_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by rst_n.
//   clk, rst_n : clock and async active-low reset
//   inc        : count enable for this cycle
//   count      : current count value
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = PIPE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Counter register; holds once all-ones is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a one-entry skid buffer and flush.
// in_ready depends only on registered occupancy and flush, so the ready path
// does not chain combinationally across stages.
//   clk, rst_n          : clock and async active-low reset
//   flush               : synchronous clear, overrides every transition
//   bus (slave)         : in_valid/in_data/in_ready, out_valid/out_data/out_ready
//   stall_cnt/flush_cnt : performance counters, present when PIPE_PERF_CNT_EN
//                         is defined, otherwise tied to zero
// Build option: `define PIPE_PERF_CNT_EN to enable the saturating counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = PIPE_DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(PIPE_NOP_DEFAULT),
  parameter int unsigned       CNT_W     = PIPE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire_c;
  logic              out_fire_c;

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign bus.in_ready  = (state_q != FULL2) & ~flush;

  assign in_fire_c  = bus.in_valid & bus.in_ready;
  assign out_fire_c = bus.out_valid & bus.out_ready;

  // State and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state logic; main always holds the oldest entry, skid the younger.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire_c) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (in_fire_c && out_fire_c) begin
            main_d = bus.in_data;
          end else if (in_fire_c) begin
            state_d = FULL2;
            skid_d  = bus.in_data;
          end else if (out_fire_c) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        FULL2: begin
          if (out_fire_c) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Stall cycles: valid entry blocked by downstream.
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.out_valid & ~bus.out_ready),
    .count (stall_cnt)
  );

  // Flushes that actually discarded something.
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush & (state_q != EMPTY)),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
